// File: rtl/muldiv_pkg.sv
// Shared constants and state encoding for the iterative RV32M multiply/divide unit.
package muldiv_pkg;

    localparam int unsigned XLEN_DEF  = 32;
    localparam int unsigned CNT_W_DEF = 5;

    // RV32M funct3 encodings; bit 2 separates divide from multiply.
    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/muldiv_div_step.sv
// One restoring-divide iteration: shift the next dividend bit into the partial
// remainder, trial-subtract the divisor, keep the difference if it did not borrow.
module muldiv_div_step
    import muldiv_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEF
) (
    input  logic [XLEN-1:0] i_rem,
    input  logic [XLEN-1:0] i_quo,
    input  logic [XLEN-1:0] i_dvs,
    output logic [XLEN-1:0] o_rem,
    output logic [XLEN-1:0] o_quo
);

    logic [XLEN:0] w_shift;
    logic [XLEN:0] w_diff;
    logic          w_borrow;

    // Partial remainder stays below the divisor, so bit XLEN of the difference is its sign.
    always_comb begin
        w_shift  = {i_rem, i_quo[XLEN-1]};
        w_diff   = w_shift - {1'b0, i_dvs};
        w_borrow = w_diff[XLEN];
        o_rem    = w_borrow ? w_shift[XLEN-1:0] : w_diff[XLEN-1:0];
        o_quo    = {i_quo[XLEN-2:0], ~w_borrow};
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: 32 radix-2 steps on operand magnitudes,
// sign fix-up on the last step, one-cycle fin pulse with a registered result.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int unsigned XLEN  = XLEN_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            is_m,
    input  logic            is_d,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] src1,
    input  logic [XLEN-1:0] src2,
    input  logic            flush,
    output logic            fin,
    output logic [XLEN-1:0] result,
    output logic            busy
);

    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    state_t          r_state, w_state_n;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]      r_op;
    logic [XLEN-1:0] r_acc, r_lo, r_opb, r_result;
    logic            r_neg_q, r_neg_r;

    logic            w_start, w_is_div, w_div0, w_ovf, w_fast;
    logic            w_a_sgn, w_b_sgn;
    logic [XLEN-1:0] w_a_mag, w_b_mag, w_fast_res;
    logic [XLEN:0]   w_mul_sum;
    logic [XLEN-1:0] w_div_rem, w_div_quo;
    logic [XLEN-1:0] w_acc_n, w_lo_n, w_quo_s, w_rem_s, w_final;
    logic [2*XLEN-1:0] w_prod, w_prod_s;

    assign w_start = (is_m | is_d) & ~flush & (r_state == ST_IDLE);
    assign result  = r_result;

    // Operand signs/magnitudes and fast-path detection, evaluated on the start cycle.
    always_comb begin
        w_is_div = funct3[2];
        if (w_is_div) begin
            w_a_sgn = ~funct3[0] & src1[XLEN-1];
            w_b_sgn = ~funct3[0] & src2[XLEN-1];
        end else begin
            w_a_sgn = ((funct3 == F3_MULH) || (funct3 == F3_MULHSU)) & src1[XLEN-1];
            w_b_sgn = (funct3 == F3_MULH) & src2[XLEN-1];
        end
        w_a_mag = w_a_sgn ? -src1 : src1;
        w_b_mag = w_b_sgn ? -src2 : src2;
        w_div0  = (src2 == '0);
        w_ovf   = ~funct3[0] & (src1 == MIN_NEG) & (src2 == '1);
        w_fast  = w_is_div & (w_div0 | w_ovf);
        if (w_div0) w_fast_res = funct3[1] ? src1 : '1;
        else        w_fast_res = funct3[1] ? '0 : MIN_NEG;
    end

    muldiv_div_step #(.XLEN(XLEN)) u_div_step (
        .i_rem (r_acc),
        .i_quo (r_lo),
        .i_dvs (r_opb),
        .o_rem (w_div_rem),
        .o_quo (w_div_quo)
    );

    // One iteration of either shift-add multiply or restoring divide, plus final sign fix-up.
    always_comb begin
        w_mul_sum = {1'b0, r_acc} + (r_lo[0] ? {1'b0, r_opb} : '0);
        w_acc_n   = r_op[2] ? w_div_rem : w_mul_sum[XLEN:1];
        w_lo_n    = r_op[2] ? w_div_quo : {w_mul_sum[0], r_lo[XLEN-1:1]};
        w_prod    = {w_acc_n, w_lo_n};
        w_prod_s  = r_neg_q ? -w_prod : w_prod;
        w_quo_s   = r_neg_q ? -w_lo_n : w_lo_n;
        w_rem_s   = r_neg_r ? -w_acc_n : w_acc_n;
        if (r_op[2])             w_final = r_op[1] ? w_rem_s : w_quo_s;
        else if (r_op == F3_MUL) w_final = w_prod_s[XLEN-1:0];
        else                     w_final = w_prod_s[2*XLEN-1:XLEN];
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rstn) r_state <= ST_IDLE;
        else       r_state <= w_state_n;
    end

    // Next-state and status outputs.
    always_comb begin
        w_state_n = r_state;
        fin       = 1'b0;
        busy      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_start) w_state_n = w_fast ? ST_DONE : ST_BUSY;
            end
            ST_BUSY: begin
                busy = 1'b1;
                if (flush)             w_state_n = ST_IDLE;
                else if (r_cnt == '0)  w_state_n = ST_DONE;
            end
            ST_DONE: begin
                busy      = 1'b1;
                fin       = 1'b1;
                w_state_n = ST_IDLE;
            end
            default: w_state_n = ST_IDLE;
        endcase
    end

    // Datapath: capture operands at start, iterate in BUSY, write result on the last step.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_cnt    <= '0;
            r_op     <= '0;
            r_acc    <= '0;
            r_lo     <= '0;
            r_opb    <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_result <= '0;
        end else if (w_start) begin
            r_op    <= funct3;
            r_acc   <= '0;
            r_lo    <= w_a_mag;
            r_opb   <= w_b_mag;
            r_neg_q <= w_a_sgn ^ w_b_sgn;
            r_neg_r <= w_a_sgn;
            if (w_fast) begin
                r_cnt    <= '0;
                r_result <= w_fast_res;
            end else begin
                r_cnt    <= '1;
            end
        end else if ((r_state == ST_BUSY) && !flush) begin
            r_acc <= w_acc_n;
            r_lo  <= w_lo_n;
            r_cnt <= r_cnt - CNT_W'(1);
            if (r_cnt == '0) r_result <= w_final;
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: latency, arithmetic, fast paths, flush and reset.
module tb_muldiv_unit;

    logic        clk;
    logic        rstn;
    logic        is_m;
    logic        is_d;
    logic [2:0]  funct3;
    logic [31:0] src1;
    logic [31:0] src2;
    logic        flush;
    logic        fin;
    logic [31:0] result;
    logic        busy;

    int total = 0;
    int bad   = 0;

    muldiv_unit #(.XLEN(32), .CNT_W(5)) dut (
        .clk    (clk),
        .rstn   (rstn),
        .is_m   (is_m),
        .is_d   (is_d),
        .funct3 (funct3),
        .src1   (src1),
        .src2   (src2),
        .flush  (flush),
        .fin    (fin),
        .result (result),
        .busy   (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one op in the current (IDLE) cycle, hold the request until fin, then check.
    task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input int exp_fin, input logic [31:0] exp_res);
        int fin_cyc;
        int nfin;
        int nbusy;
        logic [31:0] res;
        fin_cyc = -1;
        nfin    = 0;
        nbusy   = 0;
        res     = '0;
        is_m    = ~f3[2];
        is_d    = f3[2];
        funct3  = f3;
        src1    = a;
        src2    = b;
        chk({tag, "_busy_c0"}, 32'(busy), 32'd0);
        for (int c = 1; c <= 40; c++) begin
            step();
            if (busy) nbusy++;
            if (fin) begin
                nfin++;
                if (fin_cyc < 0) fin_cyc = c;
                res  = result;
                is_m = 1'b0;
                is_d = 1'b0;
            end
        end
        chk({tag, "_fin_cycle"}, 32'(fin_cyc), 32'(exp_fin));
        chk({tag, "_fin_count"}, 32'(nfin), 32'd1);
        chk({tag, "_busy_cycles"}, 32'(nbusy), 32'(exp_fin));
        chk({tag, "_result"}, res, exp_res);
        chk({tag, "_held"}, result, exp_res);
    endtask

    initial begin
        int nfin;
        int nbusy;
        int fin1;
        int fin2;

        rstn   = 1'b0;
        is_m   = 1'b0;
        is_d   = 1'b0;
        funct3 = 3'b000;
        src1   = '0;
        src2   = '0;
        flush  = 1'b0;
        repeat (3) step();
        chk("reset_fin", 32'(fin), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_result", result, 32'd0);
        rstn = 1'b1;
        step();

        // Multiply class
        run_op("mul",    3'b000, 32'd7,        32'hFFFF_FFFD, 33, 32'hFFFF_FFEB);
        run_op("mulh",   3'b001, 32'h8000_0000, 32'h8000_0000, 33, 32'h4000_0000);
        run_op("mulhu",  3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 32'hFFFF_FFFE);
        run_op("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'd2,         33, 32'hFFFF_FFFF);

        // Divide class
        run_op("div",  3'b100, 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFD);
        run_op("rem",  3'b110, 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFF);
        run_op("divu", 3'b101, 32'd100,       32'd7, 33, 32'd14);
        run_op("remu", 3'b111, 32'd100,       32'd7, 33, 32'd2);

        // Fast paths
        run_op("divu_by0", 3'b101, 32'd5,         32'd0,         1, 32'hFFFF_FFFF);
        run_op("div_ovf",  3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h8000_0000);
        run_op("rem_ovf",  3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'd0);
        run_op("remu_by0", 3'b111, 32'd5,         32'd0,         1, 32'd5);

        // Flush in cycle 10 of a MUL: abort, no fin, result stays 5
        is_m   = 1'b1;
        funct3 = 3'b000;
        src1   = 32'd3;
        src2   = 32'd4;
        for (int c = 1; c <= 10; c++) step();
        chk("flush_busy_c10", 32'(busy), 32'd1);
        flush = 1'b1;
        step();
        chk("flush_busy_c11", 32'(busy), 32'd0);
        chk("flush_fin_c11", 32'(fin), 32'd0);
        flush = 1'b0;
        is_m  = 1'b0;
        nfin  = 0;
        for (int c = 0; c < 30; c++) begin
            step();
            if (fin) nfin++;
        end
        chk("flush_no_fin", 32'(nfin), 32'd0);
        chk("flush_result_kept", result, 32'd5);

        // Flush with is_d in IDLE: never starts
        is_d   = 1'b1;
        funct3 = 3'b101;
        src1   = 32'd9;
        src2   = 32'd3;
        flush  = 1'b1;
        nbusy  = 0;
        for (int c = 0; c < 4; c++) begin
            step();
            if (busy) nbusy++;
        end
        is_d  = 1'b0;
        flush = 1'b0;
        step();
        chk("idle_flush_busy", 32'(nbusy + 32'(busy)), 32'd0);
        chk("idle_flush_result", result, 32'd5);

        // is_m held across two ops: second starts in cycle 34, fin in 67
        is_m   = 1'b1;
        funct3 = 3'b000;
        src1   = 32'd3;
        src2   = 32'd5;
        nfin   = 0;
        fin1   = -1;
        fin2   = -1;
        for (int c = 1; c <= 90; c++) begin
            step();
            if (c == 34) chk("b2b_busy_c34", 32'(busy), 32'd0);
            if (c == 35) chk("b2b_busy_c35", 32'(busy), 32'd1);
            if (fin) begin
                nfin++;
                if (nfin == 1) fin1 = c;
                if (nfin == 2) begin
                    fin2 = c;
                    is_m = 1'b0;
                end
            end
        end
        is_m = 1'b0;
        chk("b2b_fin1_cycle", 32'(fin1), 32'd33);
        chk("b2b_fin2_cycle", 32'(fin2), 32'd67);
        chk("b2b_fin_count", 32'(nfin), 32'd2);
        chk("b2b_result", result, 32'd15);

        // Synchronous reset in cycle 15 of a MUL
        is_m   = 1'b1;
        funct3 = 3'b000;
        src1   = 32'd6;
        src2   = 32'd7;
        for (int c = 1; c <= 15; c++) step();
        chk("rst_busy_c15", 32'(busy), 32'd1);
        rstn = 1'b0;
        step();
        chk("rst_fin", 32'(fin), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_result", result, 32'd0);
        rstn = 1'b1;
        is_m = 1'b0;
        nfin = 0;
        for (int c = 0; c < 40; c++) begin
            step();
            if (fin) nfin++;
        end
        chk("rst_no_fin", 32'(nfin), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative RV32M multiply/divide unit in the execute path; the hazard unit's long-instruction handshake partner.
- Sees is_m/is_d from decode, runs 32 iterations, returns a one-cycle fin pulse with a registered result.
- Hazard unit holds F/D stalled from start until fin. flush aborts an operation in flight.

Parameters:
- XLEN, 32, operand/result width; only 32 is supported.
- CNT_W, 5, iteration counter width (log2 XLEN).

Ports:
- clk  input  1  clock
- rstn  input  1  synchronous active-low reset
- is_m  input  1  decode holds a MUL-class instruction; stays high while stalled
- is_d  input  1  decode holds a DIV/REM-class instruction; stays high while stalled
- funct3  input  3  RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- src1  input  XLEN  rs1 operand (forwarded value)
- src2  input  XLEN  rs2 operand (forwarded value)
- flush  input  1  pipeline flush from hazard unit
- fin  output  1  one-cycle completion pulse
- result  output  XLEN  registered result; valid in fin cycle, held until next accepted start
- busy  output  1  high in BUSY and DONE

Behaviour:
- Reset: clk and rstn exactly as decided — reset rstn, synchronous, active-low; clock clk.
  - Reset values: state=IDLE, fin=0, busy=0, result=0, counter=0. Reset mid-operation discards all state; no fin.
- start = (is_m|is_d) & ~flush & (state==IDLE).
  - Op is selected by funct3 only; funct3[2] chooses div vs mul.
  - src1, src2 and funct3 are captured at start.
- States:
  - IDLE: on start, go to BUSY, or to DONE for fast-path. Otherwise stay.
  - BUSY: counter counts 31 down to 0, one radix-2 step per cycle. When the step at counter=0 completes, go to DONE and write result.
  - DONE: fin=1 for exactly one cycle, then IDLE. is_m/is_d are ignored in DONE; the instruction still present then is the one just finished.
- Latency, with the start cycle as cycle 0:
  - Normal ops: BUSY in cycles 1..32; fin in cycle 33.
  - Fast-path: fin in cycle 1.
- Back-to-back: is_m held high across DONE→IDLE starts the next op in the IDLE cycle, i.e. cycle 34.
- flush:
  - In IDLE with start request: no start.
  - In BUSY: abort to IDLE next cycle, no fin, result unchanged.
  - In DONE: fin still pulses.
- Multiply:
  - Shift-add on operand magnitudes into a 64-bit product.
  - Sign rules: MULH both operands signed; MULHSU src1 signed, src2 unsigned; MULHU both unsigned.
  - Final negate when the signs differ.
  - MUL returns product[31:0]; MULH/MULHSU/MULHU return product[63:32].
- Divide:
  - Restoring divide on magnitudes.
  - DIV/REM are signed: quotient negated if the signs differ, remainder takes the dividend's sign. DIVU/REMU are unsigned.
- Fast-path, decided at start:
  - src2==0: quotient=0xFFFFFFFF, remainder=src1.
  - DIV/REM with src1=0x80000000 and src2=0xFFFFFFFF: quotient=0x80000000, remainder=0.
- All arithmetic is modulo 2^XLEN. Negation of 0x80000000 yields 0x80000000 and is handled correctly as an unsigned magnitude.

Decomposition:
- Package muldiv_pkg:
  - funct3 constants: F3_MUL … F3_REMU.
  - State encoding: ST_IDLE, ST_BUSY, ST_DONE.
  - XLEN default.
- Sub-module muldiv_div_step: one combinational restoring-divide step (remainder/quotient shift, subtract, select). Instantiated once inside muldiv_unit.
- Multiply step stays inline.

Test Plan:
- MUL: is_m=1, funct3=000, src1=7, src2=0xFFFFFFFD held -> fin only in cycle 33, result=0xFFFFFFEB, busy cycles 0..33 exclusive of 0.
- MULH: 0x80000000 * 0x80000000 -> result=0x40000000. MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE. MULHSU 0xFFFFFFFF*2 -> 0xFFFFFFFF.
- DIV -7/2 (0xFFFFFFF9, 2) -> 0xFFFFFFFD at cycle 33. REM same operands -> 0xFFFFFFFF. DIVU 100/7 -> 14. REMU -> 2.
- Fast-path: DIVU 5/0 -> fin cycle 1, 0xFFFFFFFF. REMU 5/0 -> 5. DIV 0x80000000/0xFFFFFFFF -> 0x80000000. REM same -> 0.
- flush asserted in cycle 10 of a MUL -> no fin, result keeps prior value. flush with is_d in IDLE -> no start, busy stays 0.
- is_m held high across two ops; synchronous reset mid-BUSY:
  - Second MUL starts in cycle 34, fin in cycle 67; exactly two fin pulses total.
  - rstn=0 in cycle 15 -> fin=0, busy=0, result=0 next cycle.
